// File: rtl/jbi_ncio_mto_ctl.sv
`default_nettype none
// ============================================================================
// Module   : jbi_ncio_mto_ctl
// Purpose  : Non-cacheable IO transaction timeout tracker. A 16-bit prescaler
//            produces a periodic timeout_wrap tick. Four tracking slots hold
//            the tags of outstanding transactions. Each slot is armed on its
//            first tick and expires on its second tick, so a timeout fires
//            1 to 2 intervals after the grant. Expired slots become pending
//            errors. Pending errors are reported one at a time through a
//            registered valid/ack handshake.
// Ports    : clk, rst_l           - clock, asynchronous active-low reset
//            csr_mto_en           - enables the prescaler and slot aging
//            csr_mto_interval     - prescaler reload value (clk cycles)
//            alloc_req/alloc_tag  - request a slot and supply its tag
//            alloc_gnt/alloc_slot - grant and the granted slot index
//            retire_vld/slot      - completes the transaction in a slot
//            slots_full           - no slot can be allocated
//            timeout_wrap         - one-cycle prescaler tick
//            err_vld/slot/tag     - presented timeout error
//            err_ack              - consumer accepts the presented error
// Revision : 1.0 - initial release
// ============================================================================
module jbi_ncio_mto_ctl #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             csr_mto_en,
    input  logic [15:0]      csr_mto_interval,
    input  logic             alloc_req,
    input  logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_gnt,
    output logic [1:0]       alloc_slot,
    input  logic             retire_vld,
    input  logic [1:0]       retire_slot,
    output logic             slots_full,
    output logic             timeout_wrap,
    output logic             err_vld,
    output logic [1:0]       err_slot,
    output logic [TAG_W-1:0] err_tag,
    input  logic             err_ack
);

    localparam int NSLOT = 4;

    logic [15:0]      count_q, count_d;
    logic [NSLOT-1:0] vld_q, vld_d;
    logic [NSLOT-1:0] armed_q, armed_d;
    logic [NSLOT-1:0] pend_q, pend_d;
    logic [TAG_W-1:0] tag_q [NSLOT];
    logic [TAG_W-1:0] tag_d [NSLOT];
    logic             err_vld_q, err_vld_d;
    logic [1:0]       err_slot_q, err_slot_d;
    logic [TAG_W-1:0] err_tag_q, err_tag_d;

    logic [NSLOT-1:0] busy;
    logic             ack_take;
    logic [NSLOT-1:0] err_cand;

    // ------------------------------------------------------------------
    // Prescaler. While disabled it continuously preloads the interval so
    // that enabling starts a full interval. The tick is decoded straight
    // from the count, which is why a zero interval ticks every cycle.
    // ------------------------------------------------------------------
    assign timeout_wrap = csr_mto_en & (count_q == 16'd0);

    always_comb begin
        if (!csr_mto_en || (count_q == 16'd0)) begin
            count_d = csr_mto_interval;
        end else begin
            count_d = count_q - 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Allocation. A pending slot still owns its tag for error reporting,
    // so it counts as busy until its error has been acknowledged.
    // ------------------------------------------------------------------
    assign busy       = vld_q | pend_q;
    assign slots_full = &busy;
    assign alloc_gnt  = alloc_req & ~slots_full;

    always_comb begin
        alloc_slot = 2'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_slot = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot state. A fresh grant is never aged in its grant cycle (the slot
    // was not valid yet), and a retire takes priority over an expiring tick.
    // ------------------------------------------------------------------
    assign ack_take = err_vld_q & err_ack;

    always_comb begin
        vld_d   = vld_q;
        armed_d = armed_q;
        pend_d  = pend_q;
        tag_d   = tag_q;
        for (int i = 0; i < NSLOT; i++) begin
            if (alloc_gnt && (alloc_slot == 2'(i))) begin
                vld_d[i]   = 1'b1;
                armed_d[i] = 1'b0;
                tag_d[i]   = alloc_tag;
            end else if (vld_q[i]) begin
                if (retire_vld && (retire_slot == 2'(i))) begin
                    vld_d[i]   = 1'b0;
                    armed_d[i] = 1'b0;
                end else if (timeout_wrap) begin
                    if (armed_q[i]) begin
                        vld_d[i]   = 1'b0;
                        armed_d[i] = 1'b0;
                        pend_d[i]  = 1'b1;
                    end else begin
                        armed_d[i] = 1'b1;
                    end
                end
            end
            // A pending slot is never valid, so this cannot collide with
            // the pend set above.
            if (ack_take && (err_slot_q == 2'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error presentation. The slot being acknowledged this cycle is masked
    // so it is not presented a second time.
    // ------------------------------------------------------------------
    assign err_cand = pend_q & ~(ack_take ? (4'b0001 << err_slot_q) : 4'b0000);

    always_comb begin
        err_vld_d  = err_vld_q;
        err_slot_d = err_slot_q;
        err_tag_d  = err_tag_q;
        if (!err_vld_q || err_ack) begin
            err_vld_d  = |err_cand;
            err_slot_d = 2'd0;
            err_tag_d  = '0;
            for (int i = NSLOT - 1; i >= 0; i--) begin
                if (err_cand[i]) begin
                    err_slot_d = 2'(i);
                    err_tag_d  = tag_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q    <= 16'd0;
            vld_q      <= '0;
            armed_q    <= '0;
            pend_q     <= '0;
            tag_q      <= '{default: '0};
            err_vld_q  <= 1'b0;
            err_slot_q <= 2'd0;
            err_tag_q  <= '0;
        end else begin
            count_q    <= count_d;
            vld_q      <= vld_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
            tag_q      <= tag_d;
            err_vld_q  <= err_vld_d;
            err_slot_q <= err_slot_d;
            err_tag_q  <= err_tag_d;
        end
    end

    assign err_vld  = err_vld_q;
    assign err_slot = err_slot_q;
    assign err_tag  = err_tag_q;

endmodule
`default_nettype wire

// File: doc/jbi_ncio_mto_ctl.md
JBI_NCIO_MTO_CTL -- requirements
Module: jbi_ncio_mto_ctl

Interface
REQ-001 SHALL have parameter: TAG_W, 6, width of transaction tag stored per slot.
REQ-002 SHALL have port: clk  input  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port: rst_l  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: csr_mto_en  input  1  timeout engine enable.
REQ-005 SHALL have port: csr_mto_interval  input  16  prescaler reload value, in clk cycles.
REQ-006 SHALL have port: alloc_req  input  1  request one tracking slot.
REQ-007 SHALL have port: alloc_tag  input  TAG_W  tag to store on grant.
REQ-008 SHALL have port: alloc_gnt  output  1  slot granted this cycle.
REQ-009 SHALL have port: alloc_slot  output  2  granted slot index.
REQ-010 SHALL have port: retire_vld  input  1  transaction completed.
REQ-011 SHALL have port: retire_slot  input  2  slot of completed transaction.
REQ-012 SHALL have port: slots_full  output  1  no slot allocatable.
REQ-013 SHALL have port: timeout_wrap  output  1  one-cycle prescaler tick.
REQ-014 SHALL have port: err_vld  output  1  timeout error presented.
REQ-015 SHALL have port: err_slot  output  2  slot of presented error.
REQ-016 SHALL have port: err_tag  output  TAG_W  tag of presented error.
REQ-017 SHALL have port: err_ack  input  1  consumer accepts presented error.

Function
REQ-018 SHALL hold a 16-bit down counter; en=0: load csr_mto_interval every cycle, timeout_wrap=0.
REQ-019 SHALL, en=1: decrement each cycle; at count==0 assert timeout_wrap (combinational from count) for that cycle and reload csr_mto_interval.
REQ-020 SHALL, interval=0 with en=1, assert timeout_wrap every cycle; interval changes while enabled take effect at next reload only.
REQ-021 SHALL keep 4 slots, each with vld, armed, pend bits and a TAG_W tag register.
REQ-022 SHALL drive alloc_gnt = alloc_req & ~slots_full combinationally; alloc_slot = lowest index with vld=0 and pend=0 (0 when full).
REQ-023 SHALL, on grant, set vld=1, armed=0, tag=alloc_tag at the next edge.
REQ-024 SHALL drive slots_full = AND over slots of (vld | pend).
REQ-025 SHALL, on timeout_wrap, set armed=1 for each vld slot with armed=0.
REQ-026 SHALL, on timeout_wrap, for each vld slot with armed=1: clear vld and armed, set pend (error 1 to 2 intervals after grant).
REQ-027 SHALL not age a slot granted in the same cycle as timeout_wrap.
REQ-028 SHALL, on retire_vld to a vld slot, clear vld and armed at next edge; retire wins over a same-cycle timeout (no pend).
REQ-029 SHALL ignore retire_vld to a slot with vld=0, including pend slots.
REQ-030 SHALL not reallocate a slot while its pend=1.
REQ-031 SHALL register err_vld/err_slot/err_tag; when err_vld=0 or err_ack=1, load lowest pend slot not being acked, else hold.
REQ-032 SHALL, on err_vld & err_ack, clear that slot's pend at the edge; err_ack with err_vld=0 is ignored.
REQ-033 SHALL keep err_slot/err_tag stable while err_vld=1 and err_ack=0, even if a lower slot becomes pend.
REQ-034 SHALL present an error one cycle after its pend sets (pend at edge N, err_vld at edge N+1 when idle).
REQ-035 SHALL, en=0, freeze aging (vld/armed retained), still allow alloc/retire and error reporting.

Reset
REQ-036 SHALL, on rst_l=0, asynchronously clear counter, all vld/armed/pend/tag, err_vld, err_slot, err_tag to 0.
REQ-037 SHALL, with en=1 from reset, assert timeout_wrap on the first cycle (count=0), then follow the interval.
REQ-038 SHALL, rst_l mid-transaction, drop all slots and pending errors with no error reported.

Verification
REQ-039 SHALL cover: interval=3, en=1 -> timeout_wrap every 4th cycle; interval=0 -> every cycle.
REQ-040 SHALL cover: 5 back-to-back alloc_req, no retire -> grants slots 0,1,2,3, fifth denied, slots_full=1.
REQ-041 SHALL cover: alloc tag 0x2A to slot 0, no retire, interval=3 -> pend after second wrap, err_vld=1, err_slot=0, err_tag=0x2A next cycle.
REQ-042 SHALL cover: retire slot 1 in same cycle as its expiring wrap -> no error, slot 1 reallocatable next cycle.
REQ-043 SHALL cover: slots 2 then 0 time out while err_ack held 0 -> err_slot stays 2; ack -> err_slot 0 next cycle; ack -> err_vld=0.
REQ-044 SHALL cover: rst_l pulsed low with 3 vld slots and 1 pend -> all outputs 0 immediately, slots_full=0.
